crc16_checker: RTL and testbench

Receive-side counterpart of `crc16_generator`. It takes a captured frame word plus the 16-bit CRC that travelled with it. It recomputes the CRC one byte per clock and reports pass/fail with a one-cycle `valid` strobe. It sits after the frame deserializer and keeps a saturating error counter for link-quality monitoring. The CRC algorithm matches `crc16_generator` exactly: CRC-16/CCITT-FALSE, poly 0x1021, init 0xFFFF, no reflection, no final XOR.

---
 rtl/crc16_checker.sv | 142 ++++++++++++++
 tb/tb_crc16_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_checker.sv
// ---------------------------------------------------------------------------
// crc16_checker
//
// Receive-side CRC-16/CCITT-FALSE checker (poly 0x1021, init 0xFFFF, no
// reflection, no final XOR). A captured frame payload and the CRC that
// travelled with it are latched on an accepted start. The CRC is then
// recomputed one byte per clock, most significant payload byte first. The
// pass/fail result is reported with a one-cycle valid strobe. Failed checks
// are tallied in a saturating 16-bit counter for link-quality monitoring.
//
// Ports:
//   clk          in   1             rising-edge clock
//   rst          in   1             synchronous reset, active low
//   data_in_ori  in   8*DATA_BYTES  frame payload, MSB byte processed first
//   crc_in       in   16            received CRC to compare against
//   start        in   1             request a check (sampled when not busy)
//   busy         out  1             check in progress
//   valid        out  1             one-cycle result strobe
//   crc_ok       out  1             recomputed CRC matched crc_in
//   crc_calc     out  16            recomputed CRC of the last frame
//   err_cnt      out  16            saturating count of failed checks
// ---------------------------------------------------------------------------
module crc16_checker #(
    parameter int          DATA_BYTES = 12,
    parameter logic [15:0] POLY       = 16'h1021,
    parameter logic [15:0] INIT       = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*DATA_BYTES-1:0]   data_in_ori,
    input  logic [15:0]               crc_in,
    input  logic                      start,
    output logic                      busy,
    output logic                      valid,
    output logic                      crc_ok,
    output logic [15:0]               crc_calc,
    output logic [15:0]               err_cnt
);

    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int CNT_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES - 1);

    // One byte of MSB-first polynomial division. The byte is folded into the
    // top of the register, then eight shift/conditional-XOR steps are unrolled.
    function automatic logic [15:0] crc_byte_update(input logic [15:0] crc,
                                                    input logic [7:0]  data_byte);
        logic [15:0] c;
        c = crc ^ {data_byte, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) begin
                c = {c[14:0], 1'b0} ^ POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [1:0]        state_r;
    logic [DATA_W-1:0] shift_r;
    logic [15:0]       crc_in_r;
    logic [15:0]       crc_reg_r;
    logic [CNT_W-1:0]  byte_cnt_r;
    logic              valid_r;
    logic              crc_ok_r;
    logic [15:0]       crc_calc_r;
    logic [15:0]       err_cnt_r;

    logic [15:0]       crc_next_s;
    logic              last_byte_s;
    logic              match_s;

    // Next CRC value for the byte currently at the top of the shift register.
    always_comb begin
        crc_next_s  = crc_byte_update(crc_reg_r, shift_r[DATA_W-1 -: 8]);
        last_byte_s = (byte_cnt_r == LAST_BYTE);
        match_s     = (crc_next_s == crc_in_r);
    end

    // Check sequencer: latch frame, run byte updates, publish result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            crc_in_r   <= 16'h0000;
            crc_reg_r  <= 16'h0000;
            byte_cnt_r <= '0;
            valid_r    <= 1'b0;
            crc_ok_r   <= 1'b0;
            crc_calc_r <= 16'h0000;
            err_cnt_r  <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // DONE is the single cycle the strobe is high.
                    valid_r <= 1'b0;
                    if (start) begin
                        state_r    <= ST_CALC;
                        shift_r    <= data_in_ori;
                        crc_in_r   <= crc_in;
                        crc_reg_r  <= INIT;
                        byte_cnt_r <= '0;
                        crc_ok_r   <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    crc_reg_r  <= crc_next_s;
                    shift_r    <= shift_r << 8;
                    byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                    if (last_byte_s) begin
                        state_r    <= ST_DONE;
                        crc_calc_r <= crc_next_s;
                        crc_ok_r   <= match_s;
                        valid_r    <= 1'b1;
                        if (!match_s && (err_cnt_r != 16'hFFFF)) begin
                            err_cnt_r <= err_cnt_r + 16'h0001;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (state_r == ST_CALC);
    assign valid    = valid_r;
    assign crc_ok   = crc_ok_r;
    assign crc_calc = crc_calc_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_crc16_checker.sv
// ---------------------------------------------------------------------------
// tb_crc16_checker
//
// Directed bench for crc16_checker. Two instances share one clock and one
// reset: a 9-byte instance checks the well-known "123456789" vector, and a
// default 12-byte instance checks loopback, back-to-back, reset and
// saturation behaviour. Inputs change on the falling edge, and outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_crc16_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [71:0] d9_data;
    logic [15:0] d9_crc_in;
    logic        d9_start;
    logic        d9_busy, d9_valid, d9_ok;
    logic [15:0] d9_calc, d9_err;

    logic [95:0] d12_data;
    logic [15:0] d12_crc_in;
    logic        d12_start;
    logic        d12_busy, d12_valid, d12_ok;
    logic [15:0] d12_calc, d12_err;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [95:0] LOOP_DATA = 96'hAA5500112233445566778899;
    logic [15:0] loop_crc;

    crc16_checker #(.DATA_BYTES(9)) dut9 (
        .clk(clk), .rst(rst), .data_in_ori(d9_data), .crc_in(d9_crc_in),
        .start(d9_start), .busy(d9_busy), .valid(d9_valid), .crc_ok(d9_ok),
        .crc_calc(d9_calc), .err_cnt(d9_err)
    );

    crc16_checker dut12 (
        .clk(clk), .rst(rst), .data_in_ori(d12_data), .crc_in(d12_crc_in),
        .start(d12_start), .busy(d12_busy), .valid(d12_valid), .crc_ok(d12_ok),
        .crc_calc(d12_calc), .err_cnt(d12_err)
    );

    // Bit-serial reference CRC, standing in for crc16_generator.
    function automatic logic [15:0] crc_ref(input logic [95:0] d, input int nbytes);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = nbytes * 8 - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Pulse start. The task returns on the falling edge just after acceptance.
    task automatic start_pulse(input bit sel);
        @(negedge clk);
        if (sel) d12_start = 1'b1; else d9_start = 1'b1;
        @(negedge clk);
        d12_start = 1'b0;
        d9_start  = 1'b0;
    endtask

    // Count falling edges until valid is seen, bounded by limit.
    task automatic wait_valid(input bit sel, input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(sel ? d12_valid : d9_valid) && cycles < limit);
        if (!(sel ? d12_valid : d9_valid)) cycles = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        d9_start = 1'b0; d12_start = 1'b0;
        d9_data = '0; d12_data = '0; d9_crc_in = 16'h0000; d12_crc_in = 16'h0000;
        repeat (2) @(negedge clk);
        n_cmp++; if ({d9_busy, d9_valid, d9_ok, d9_calc, d9_err} !== 35'h0) begin
            n_fail++; $display("FAIL reset9: got %h required 0", {d9_busy, d9_valid, d9_ok, d9_calc, d9_err}); end
        n_cmp++; if ({d12_busy, d12_valid, d12_ok, d12_calc, d12_err} !== 35'h0) begin
            n_fail++; $display("FAIL reset12: got %h required 0", {d12_busy, d12_valid, d12_ok, d12_calc, d12_err}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known_vector();
        int cyc;
        d9_data = 72'h313233343536373839; d9_crc_in = 16'h29B1;
        start_pulse(1'b0);
        n_cmp++; if (d9_busy !== 1'b1) begin n_fail++; $display("FAIL kv_busy: got %b required 1", d9_busy); end
        wait_valid(1'b0, 30, cyc);
        n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL kv_latency: got %0d required 9", cyc); end
        n_cmp++; if (d9_calc !== 16'h29B1) begin n_fail++; $display("FAIL kv_calc: got %h required 29b1", d9_calc); end
        n_cmp++; if (d9_ok !== 1'b1) begin n_fail++; $display("FAIL kv_ok: got %b required 1", d9_ok); end
        n_cmp++; if (d9_err !== 16'h0000) begin n_fail++; $display("FAIL kv_err: got %h required 0", d9_err); end
        n_cmp++; if (d9_busy !== 1'b0) begin n_fail++; $display("FAIL kv_busy_done: got %b required 0", d9_busy); end
        @(negedge clk);
        n_cmp++; if (d9_valid !== 1'b0) begin n_fail++; $display("FAIL kv_strobe: got %b required 0", d9_valid); end
        n_cmp++; if (d9_calc !== 16'h29B1 || d9_ok !== 1'b1) begin
            n_fail++; $display("FAIL kv_hold: got %h/%b required 29b1/1", d9_calc, d9_ok); end
    endtask

    task automatic test_corruption();
        int cyc;
        d9_crc_in = 16'h29B0;
        start_pulse(1'b0);
        n_cmp++; if (d9_ok !== 1'b0) begin n_fail++; $display("FAIL cor_ok_clear: got %b required 0", d9_ok); end
        wait_valid(1'b0, 30, cyc);
        n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL cor_latency: got %0d required 9", cyc); end
        n_cmp++; if (d9_calc !== 16'h29B1) begin n_fail++; $display("FAIL cor_calc: got %h required 29b1", d9_calc); end
        n_cmp++; if (d9_ok !== 1'b0) begin n_fail++; $display("FAIL cor_ok: got %b required 0", d9_ok); end
        n_cmp++; if (d9_err !== 16'h0001) begin n_fail++; $display("FAIL cor_err1: got %h required 1", d9_err); end
        d9_data = 72'h313233343536373838; d9_crc_in = 16'h29B1;
        start_pulse(1'b0);
        wait_valid(1'b0, 30, cyc);
        n_cmp++; if (d9_ok !== 1'b0) begin n_fail++; $display("FAIL cor_bit_ok: got %b required 0", d9_ok); end
        n_cmp++; if (d9_err !== 16'h0002) begin n_fail++; $display("FAIL cor_err2: got %h required 2", d9_err); end
    endtask

    task automatic test_loopback();
        int cyc;
        d12_data = LOOP_DATA; d12_crc_in = loop_crc;
        start_pulse(1'b1);
        wait_valid(1'b1, 40, cyc);
        n_cmp++; if (cyc !== 12) begin n_fail++; $display("FAIL lb_latency: got %0d required 12", cyc); end
        n_cmp++; if (d12_ok !== 1'b1) begin n_fail++; $display("FAIL lb_ok: got %b required 1", d12_ok); end
        n_cmp++; if (d12_calc !== loop_crc) begin n_fail++; $display("FAIL lb_calc: got %h required %h", d12_calc, loop_crc); end
        d12_crc_in = ~loop_crc;
        start_pulse(1'b1);
        wait_valid(1'b1, 40, cyc);
        n_cmp++; if (d12_ok !== 1'b0) begin n_fail++; $display("FAIL lb_inv_ok: got %b required 0", d12_ok); end
        n_cmp++; if (d12_err !== 16'h0001) begin n_fail++; $display("FAIL lb_inv_err: got %h required 1", d12_err); end
    endtask

    task automatic test_back_to_back();
        int cnt, nv, last;
        d12_data = LOOP_DATA; d12_crc_in = loop_crc;
        @(negedge clk);
        d12_start = 1'b1;
        cnt = 0; nv = 0; last = 0;
        while (nv < 5 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (d12_valid) begin
                nv++;
                n_cmp++; if ((cnt - last) !== 13) begin
                    n_fail++; $display("FAIL b2b_period%0d: got %0d required 13", nv, cnt - last); end
                n_cmp++; if (d12_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_ok%0d: got %b required 1", nv, d12_ok); end
                last = cnt;
                if (nv == 5) d12_start = 1'b0;
            end
        end
        n_cmp++; if (nv !== 5) begin n_fail++; $display("FAIL b2b_count: got %0d required 5", nv); end
        @(negedge clk);
        n_cmp++; if ({d12_busy, d12_valid} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_idle: got %b required 00", {d12_busy, d12_valid}); end
        n_cmp++; if (d12_err !== 16'h0001) begin n_fail++; $display("FAIL b2b_err: got %h required 1", d12_err); end

        // Disturb start and the inputs while the frame is in flight.
        start_pulse(1'b1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt <= 6) begin
                d12_start  = cnt[0];
                d12_data   = {$urandom, $urandom, $urandom};
                d12_crc_in = 16'($urandom);
            end else begin
                d12_start = 1'b0;
            end
        end while (!d12_valid && cnt < 40);
        n_cmp++; if (cnt !== 12) begin n_fail++; $display("FAIL busy_latency: got %0d required 12", cnt); end
        n_cmp++; if (d12_ok !== 1'b1 || d12_calc !== loop_crc) begin
            n_fail++; $display("FAIL busy_result: got %b/%h required 1/%h", d12_ok, d12_calc, loop_crc); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, seen;
        d12_data = LOOP_DATA; d12_crc_in = ~loop_crc;
        start_pulse(1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_cmp++; if ({d12_busy, d12_valid, d12_ok, d12_calc, d12_err} !== 35'h0) begin
            n_fail++; $display("FAIL rmid_outputs: got %h required 0", {d12_busy, d12_valid, d12_ok, d12_calc, d12_err}); end
        n_cmp++; if (d9_err !== 16'h0000) begin n_fail++; $display("FAIL rmid_err9: got %h required 0", d9_err); end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (d12_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rmid_novalid: got %0d required 0", seen); end
        n_cmp++; if (d12_err !== 16'h0000) begin n_fail++; $display("FAIL rmid_err: got %h required 0", d12_err); end
        d12_crc_in = loop_crc;
        start_pulse(1'b1);
        wait_valid(1'b1, 40, cyc);
        n_cmp++; if (cyc !== 12 || d12_ok !== 1'b1) begin
            n_fail++; $display("FAIL rmid_next: got %0d/%b required 12/1", cyc, d12_ok); end
    endtask

    task automatic test_saturation();
        int cyc;
        logic [15:0] exp_err;
        @(negedge clk);
        force dut12.err_cnt_r = 16'hFFFE;
        @(negedge clk);
        release dut12.err_cnt_r;
        @(negedge clk);
        n_cmp++; if (d12_err !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h required fffe", d12_err); end
        d12_data = LOOP_DATA; d12_crc_in = ~loop_crc;
        for (int i = 0; i < 3; i++) begin
            start_pulse(1'b1);
            wait_valid(1'b1, 40, cyc);
            exp_err = 16'hFFFF;
            n_cmp++; if (d12_err !== exp_err || d12_ok !== 1'b0) begin
                n_fail++; $display("FAIL sat_run%0d: got %h/%b required %h/0", i, d12_err, d12_ok, exp_err); end
        end
    endtask

    initial begin
        loop_crc = crc_ref(LOOP_DATA, 12);
        test_reset();
        test_known_vector();
        test_corruption();
        test_loopback();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
